hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Issue controller between the fetch/decode boundary and the execute stage of the pipelined MIPS core.
- Tracks in-flight destination registers with per-register countdown counters. Stalls decode on read-after-write hazards, squashes wrong-path instructions after a taken branch, and provides a drain handshake for halt/exception entry.
- Drives the decode stage's hold and the pipeline-register bubble insertion.

Parameters:
- NUM_REGS, 32, architectural register count; index 0 is hard-wired zero.
- LAT_ALU, 3, cycles from issue until an ALU result is written back (1..7).
- LAT_LOAD, 4, cycles from issue until load data is written back (1..7, >= LAT_ALU).
- FLUSH_CYCLES, 2, wrong-path slots squashed after a taken branch (1..3).

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs  in  5  source register 1 field
- id_rt  in  5  source register 2 field
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_dest  in  5  destination register (after RegDST mux)
- id_regwrite  in  1  RegWrite control bit
- id_memread  in  1  MemRead control bit (load)
- branch_taken  in  1  EX resolved a taken branch this cycle
- wb_valid  in  1  register-file write occurs this cycle
- wb_rd  in  5  register being written
- drain_req  in  1  level request to quiesce the pipeline
- stall  out  1  hold PC/IF-ID, insert bubble
- issue  out  1  instruction advances to EX this cycle
- flush  out  1  squash IF/ID contents this cycle
- drain_ack  out  1  pipeline empty, no issue in progress
- busy_mask  out  NUM_REGS  per-register pending-write bits

Behaviour:
Reset (async, Rst=1):
- All counters 0.
- State RUN.
- Outputs: busy_mask=0, flush=0, drain_ack=0.
- stall and issue follow from id_valid per the equations below; with counters at 0 in RUN, a valid instruction issues.

Scoreboard:
- One CNT_W=3-bit counter per register plus a load flag.
- busy[r] = (cnt[r]!=0). busy[0] is always 0; writes to register 0 are never recorded.
- Each cycle, a nonzero counter decrements by 1.
- wb_valid with wb_rd=r forces cnt[r]=0 (early completion).
- On issue with id_regwrite and id_dest!=0: cnt[id_dest] loads LAT_LOAD if id_memread, else LAT_ALU; the load flag takes id_memread.
- Same-cycle issue and wb to the same register: the issue load wins.
- Re-issue to an already-busy register: the counter reloads (WAW handled by the latest writer).

Hazard:
- hz = (id_uses_rs & id_rs!=0 & busy[id_rs]) | (id_uses_rt & id_rt!=0 & busy[id_rt]).
- Busy state is evaluated from the registered counters before this cycle's updates.

FSM states: RUN, FLUSH, DRAIN, HALTED.
- RUN:
  - stall = id_valid & hz.
  - issue = id_valid & ~hz & ~branch_taken.
  - branch_taken has priority over everything: go to FLUSH, load the flush counter with FLUSH_CYCLES, flush=1 in the same cycle.
  - Otherwise, drain_req: go to DRAIN.
- FLUSH:
  - flush=1, issue=0, stall=0.
  - Decrement the flush counter; return to RUN when it reaches 0.
  - A branch_taken arriving while in FLUSH reloads the counter.
- DRAIN:
  - issue=0, stall=id_valid.
  - When busy_mask==0: go to HALTED.
  - A branch_taken arriving in DRAIN asserts flush for one cycle and stays in DRAIN.
- HALTED:
  - drain_ack=1, issue=0, stall=id_valid.
  - Deassertion of drain_req returns to RUN the next cycle, with drain_ack=0.

Ordering and mid-operation reset:
- stall, issue and flush are combinational from state and inputs; all state updates on the Clk rising edge.
- Rst mid-operation clears everything immediately; the next instruction issues without waiting.

Optional Feature:
Macro HAZARD_BYPASS_EN.
- Defined: a source whose counter equals 1 and whose load flag is 0 is treated as not busy for hz, because the forwarding path supplies it. Load results still stall until the counter reaches 0.
- Undefined: any nonzero counter stalls.
- busy_mask is identical in both builds.

Test Plan:
- Reset while counters are loaded: Rst pulse mid-cycle -> busy_mask=0, state RUN, flush=0 asynchronously; id_valid=1 with no hazard gives issue=1 next cycle.
- ALU RAW: issue add with dest=$8, then add reading rs=$8 -> stall=1 for LAT_ALU=3 cycles; issue on the 4th cycle. With HAZARD_BYPASS_EN: stall for 2 cycles.
- Load-use: lw dest=$9 followed by a reader of rt=$9 -> stall for 4 cycles in both builds; wb_valid wb_rd=9 after 2 cycles clears the stall the next cycle.
- Register zero: writer to $0 then reader of $0 -> busy_mask=0, no stall.
- Taken branch: branch_taken=1 in RUN -> flush=1 for 2 cycles, issue=0; a second branch_taken in FLUSH extends it to 2 more cycles.
- Drain: $5 busy with cnt=3, drain_req=1 -> issue=0; drain_ack rises once busy_mask==0; drop drain_req -> RUN and issue resume the next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue controller between decode and execute.
// It keeps a countdown per destination register so decode can be held on
// read-after-write hazards. It squashes wrong-path slots after a taken branch
// and runs a drain/halt handshake.
// Optional feature macro: HAZARD_BYPASS_EN. When it is defined, an ALU result
// one cycle from writeback is taken from the forwarding path instead of
// stalling decode.
// Ports:
//   Clk, Rst            clock, asynchronous active-high reset
//   id_*                decoded instruction fields and control bits
//   branch_taken        EX resolved a taken branch
//   wb_valid, wb_rd     register-file write (completes a pending write early)
//   drain_req           level request to quiesce the pipeline
//   stall, issue, flush decode hold, advance to EX, squash IF/ID
//   drain_ack           pipeline empty while halted
//   busy_mask           per-register pending-write bits
//
// state  | meaning
// RUN    | normal issue, hazards stall decode
// FLUSH  | squashing wrong-path slots after a taken branch
// DRAIN  | no issue, waiting for all pending writes to retire
// HALTED | quiescent, drain_ack high until drain_req drops
module hazard_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int LAT_ALU      = 3,
  parameter int LAT_LOAD     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                id_valid,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic [4:0]          id_dest,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                branch_taken,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic                drain_req,
  output logic                stall,
  output logic                issue,
  output logic                flush,
  output logic                drain_ack,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;

  state_t              state_q, state_d;
  logic [1:0]          fcnt_q, fcnt_d;
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] ld_q, ld_d;
  logic [NUM_REGS-1:0] hz_mask;
  logic                hz;

  always_comb begin
    busy_mask = '0;
    hz_mask   = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_mask[r] = (cnt_q[r] != '0);
`ifdef HAZARD_BYPASS_EN
      // An ALU result one cycle from writeback is available on the forwarding path.
      hz_mask[r] = busy_mask[r] & ~((cnt_q[r] == CNT_W'(1)) & ~ld_q[r]);
`else
      hz_mask[r] = busy_mask[r];
`endif
    end
  end

  assign hz = (id_uses_rs & (id_rs != 5'd0) & hz_mask[id_rs]) |
              (id_uses_rt & (id_rt != 5'd0) & hz_mask[id_rt]);

  // Scoreboard update. An issue load overrides a same-cycle writeback.
  always_comb begin
    cnt_d[0] = '0;
    ld_d     = ld_q;
    ld_d[0]  = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
      if (wb_valid && (wb_rd == 5'(r)))
        cnt_d[r] = '0;
      if (issue && id_regwrite && (id_dest == 5'(r))) begin
        cnt_d[r] = id_memread ? CNT_W'(LAT_LOAD) : CNT_W'(LAT_ALU);
        ld_d[r]  = id_memread;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      ld_q    <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ld_q    <= ld_d;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // FLUSH lasts FLUSH_CYCLES cycles after the branch cycle. A branch seen
  // during FLUSH restarts that window.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          state_d = FLUSH;
          fcnt_d  = 2'(FLUSH_CYCLES);
        end else if (drain_req) begin
          state_d = DRAIN;
        end
      end
      FLUSH: begin
        if (branch_taken) begin
          fcnt_d = 2'(FLUSH_CYCLES);
        end else begin
          fcnt_d = fcnt_q - 2'd1;
          if (fcnt_q <= 2'd1) state_d = RUN;
        end
      end
      DRAIN: begin
        if (busy_mask == '0) state_d = HALTED;
      end
      HALTED: begin
        if (!drain_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    issue     = 1'b0;
    flush     = 1'b0;
    drain_ack = 1'b0;
    unique case (state_q)
      RUN: begin
        stall = id_valid & hz;
        issue = id_valid & ~hz & ~branch_taken;
        flush = branch_taken;
      end
      FLUSH: flush = 1'b1;
      DRAIN: begin
        stall = id_valid;
        flush = branch_taken;
      end
      HALTED: begin
        stall     = id_valid;
        drain_ack = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int NR = 32;
  localparam int LA = 3;
  localparam int LL = 4;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 0, id_uses_rs = 0, id_uses_rt = 0;
  logic          id_regwrite = 0, id_memread = 0, branch_taken = 0;
  logic          wb_valid = 0, drain_req = 0;
  logic [4:0]    id_rs = 0, id_rt = 0, id_dest = 0, wb_rd = 0;
  logic          stall, issue, flush, drain_ack;
  logic [NR-1:0] busy_mask;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: absolute cycle at which each pending write is done.
  int t = 0;
  int done_at [NR];
  bit is_ld [NR];
  int flush_start = 0, flush_end = 0;
  bit draining = 0, halted = 0;

  hazard_scoreboard #(.NUM_REGS(NR), .LAT_ALU(LA), .LAT_LOAD(LL), .FLUSH_CYCLES(FC)) dut (
    .Clk(clk), .Rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .drain_req(drain_req), .stall(stall),
    .issue(issue), .flush(flush), .drain_ack(drain_ack), .busy_mask(busy_mask));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      done_at[r] = 0;
      is_ld[r] = 0;
    end
    flush_start = 0;
    flush_end = 0;
    draining = 0;
    halted = 0;
  endtask

  function automatic bit m_busy(input int r);
    return (r != 0) && (t < done_at[r]);
  endfunction

  function automatic bit m_hz_busy(input int r);
`ifdef HAZARD_BYPASS_EN
    return m_busy(r) && !((t == done_at[r] - 1) && !is_ld[r]);
`else
    return m_busy(r);
`endif
  endfunction

  task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input int dst, input bit rw, input bit mr, input bit bt,
                      input bit wv, input int wrd, input bit dr);
    bit hz, in_flush, e_stall, e_issue, e_flush, e_ack, all_idle;
    logic [NR-1:0] e_mask;
    @(negedge clk);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_dest = 5'(dst); id_regwrite = rw; id_memread = mr; branch_taken = bt;
    wb_valid = wv; wb_rd = 5'(wrd); drain_req = dr;
    #1;
    e_mask = '0;
    for (int r = 0; r < NR; r++) e_mask[r] = m_busy(r);
    all_idle = (e_mask == '0);
    hz = (urs && rs != 0 && m_hz_busy(rs)) || (urt && rt != 0 && m_hz_busy(rt));
    in_flush = (t >= flush_start) && (t < flush_end);
    e_stall = 0; e_issue = 0; e_flush = 0; e_ack = 0;
    if (in_flush) e_flush = 1;
    else if (draining) begin e_stall = v; e_flush = bt; end
    else if (halted) begin e_stall = v; e_ack = 1; end
    else begin
      e_stall = v && hz;
      e_issue = v && !hz && !bt;
      e_flush = bt;
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("issue", 32'(issue), 32'(e_issue));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("drain_ack", 32'(drain_ack), 32'(e_ack));
    chk("busy_mask", busy_mask, e_mask);
    @(posedge clk);
    if (in_flush) begin
      if (bt) begin flush_start = t + 1; flush_end = t + 1 + FC; end
    end else if (draining) begin
      if (all_idle) begin draining = 0; halted = 1; end
    end else if (halted) begin
      if (!dr) halted = 0;
    end else if (bt) begin
      flush_start = t + 1; flush_end = t + 1 + FC;
    end else if (dr) draining = 1;
    if (wv && wrd != 0) done_at[wrd] = t + 1;
    if (e_issue && rw && dst != 0) begin
      done_at[dst] = t + 1 + (mr ? LL : LA);
      is_ld[dst] = mr;
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit dr_lvl;
    model_reset();
    #12 rst = 0;

    // Reset with counters loaded and inside FLUSH.
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    id_valid = 0; branch_taken = 0; wb_valid = 0; drain_req = 0;
    #1 rst = 1;
    #1;
    chk("rst_busy_mask", busy_mask, '0);
    chk("rst_flush", 32'(flush), 32'(0));
    chk("rst_drain_ack", 32'(drain_ack), 32'(0));
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    t++;
    step(1, 5, 5, 1, 1, 6, 0, 0, 0, 0, 0, 0);

    // ALU RAW on $8.
    step(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8, 0, 1, 0, 10, 0, 0, 0, 0, 0, 0);
    idle(4);
    // Load-use on $9, then with early writeback after 2 cycles.
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 9, 0, 1, 11, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);
    step(1, 0, 9, 0, 1, 11, 0, 0, 0, 0, 0, 0);
    step(1, 0, 9, 0, 1, 11, 0, 0, 0, 1, 9, 0);
    step(1, 0, 9, 0, 1, 11, 0, 0, 0, 0, 0, 0);
    idle(4);
    // Register zero.
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 12, 0, 0, 0, 0, 0, 0);
    // Taken branch, then a second one during FLUSH.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Drain with $5 busy.
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 1);
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0);
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    dr_lvl = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) dr_lvl = ~dr_lvl;
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)), dr_lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
